// File: rtl/match_window_counter.sv
// match_window_counter
//   Counts rising edges of the sequence-detector match flag z_in over a
//   programmable window of bit-cycles. At the end of the window it raises
//   done for one cycle and reports the count and a threshold alarm.
//
//   Optional feature macro: MATCH_CNT_SAT_EN
//     defined   -> match_count saturates at all-ones
//     undefined -> match_count wraps modulo 2^CNT_W
//
//   A window of length L accepted at edge k spends L cycles in COUNT and
//   shows DONE right after edge k+L. A zero-length window goes straight
//   from IDLE to DONE on the accepting edge.
module match_window_counter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] threshold,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             z_d;          // previous-cycle z_in, for edge detection
    logic [WIN_W-1:0] remaining;    // cycles left in the current window
    logic [CNT_W-1:0] thr_q;        // threshold latched at window start

    logic             accept;
    logic             zero_win;
    logic             last;
    logic             match;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] count_nxt;

    // Decode the per-cycle events used by both the FSM and the datapath
    always_comb begin
        accept   = (state == IDLE) && start;
        zero_win = (window_len == '0);
        // remaining never sits at 0 inside COUNT; <= keeps the FSM safe anyway
        last     = (state == COUNT) && (remaining <= WIN_W'(1));
        // a match is a rising edge of z_in; a level held high counts once
        match    = (state == COUNT) && z_in && !z_d;
    end

    // Incremented count, saturating or wrapping depending on the build
    always_comb begin
`ifdef MATCH_CNT_SAT_EN
        count_inc = (match_count == '1) ? match_count : match_count + CNT_W'(1);
`else
        count_inc = match_count + CNT_W'(1);
`endif
        count_nxt = match ? count_inc : match_count;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_win ? DONE : COUNT;
            COUNT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        busy = (state == COUNT) || (state == DONE);
        done = (state == DONE);
    end

    // Input history: z_d tracks z_in in every state, start does not clear it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) z_d <= 1'b0;
        else     z_d <= z_in;
    end

    // Window datapath: latch on start, count and decrement in COUNT,
    // register the alarm on the edge that enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining   <= '0;
            thr_q       <= '0;
            match_count <= '0;
            alarm       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        remaining   <= window_len;
                        thr_q       <= threshold;
                        match_count <= '0;
                        // zero-length window enters DONE now with a count of 0
                        alarm       <= zero_win && (threshold == '0);
                    end
                end
                COUNT: begin
                    remaining   <= remaining - WIN_W'(1);
                    match_count <= count_nxt;
                    if (last) alarm <= (count_nxt >= thr_q);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
